// File: rtl/if_fetch_queue.sv
// Pipelined instruction fetch: issues up to MAX_OUTSTANDING inst_sram requests and buffers responses in an IQ_DEPTH queue.
// Define IF_FETCH_PERF_EN to add the perf_fetch_cnt / perf_cancel_cnt counter outputs.
module if_fetch_queue #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned IQ_DEPTH        = 4,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_excep_en,
    output logic [5:0]  out_ecode
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_cancel_cnt
`endif
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam int unsigned AW  = $clog2(IQ_DEPTH);
    localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   fetch_pc;
    logic          halt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] cancel_cnt;

    logic [31:0]    pend_pc [MAX_OUTSTANDING];
    logic [PAW-1:0] pend_wr;
    logic [PAW-1:0] pend_rd;

    logic [31:0] iq_pc   [IQ_DEPTH];
    logic [31:0] iq_inst [IQ_DEPTH];
    logic        iq_exc  [IQ_DEPTH];
    logic [AW:0] iq_wr;
    logic [AW:0] iq_rd;
    logic [AW:0] iq_count;
    logic        iq_empty;
    logic        iq_full;

    logic        issue;
    logic        resp_keep;
    logic        resp_drop;
    logic        adef_push;
    logic        iq_push;
    logic        iq_pop;
    logic        room;
    logic [31:0] push_pc;
    logic [31:0] push_inst;

    function automatic logic [PAW-1:0] pend_next(input logic [PAW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PAW'(1);
    endfunction

    always_comb begin
        iq_count  = iq_wr - iq_rd;
        iq_empty  = (iq_wr == iq_rd);
        iq_full   = (32'(iq_count) == IQ_DEPTH);
        // Every accepted request reserves a queue slot so a response can never overflow it.
        room      = (32'(iq_count) + 32'(outstanding)) < IQ_DEPTH;
        inst_sram_req = resetn & ~halt & ~fetch_stall & ~redirect_valid
                      & (fetch_pc[1:0] == 2'b00)
                      & (32'(outstanding) < MAX_OUTSTANDING) & room;
        inst_sram_addr = fetch_pc;
        issue     = inst_sram_req & inst_sram_addr_ok;
        resp_keep = inst_sram_data_ok & (cancel_cnt == '0) & ~redirect_valid;
        resp_drop = inst_sram_data_ok & (cancel_cnt != '0);
        adef_push = ~redirect_valid & ~halt & (fetch_pc[1:0] != 2'b00)
                  & (outstanding == '0) & (cancel_cnt == '0) & ~iq_full;
        iq_push   = resp_keep | adef_push;
        iq_pop    = ~iq_empty & out_ready & ~redirect_valid;
        push_pc   = adef_push ? fetch_pc : pend_pc[pend_rd];
        push_inst = adef_push ? 32'h0 : inst_sram_rdata;
    end

    assign out_valid    = ~iq_empty;
    assign out_pc       = iq_pc[iq_rd[AW-1:0]];
    assign out_inst     = iq_inst[iq_rd[AW-1:0]];
    assign out_excep_en = iq_exc[iq_rd[AW-1:0]];
    assign out_ecode    = iq_exc[iq_rd[AW-1:0]] ? 6'h08 : 6'h00;

    always_ff @(posedge clk) begin
        if (issue) pend_pc[pend_wr] <= fetch_pc;
        if (iq_push && !redirect_valid) begin
            iq_pc[iq_wr[AW-1:0]]   <= push_pc;
            iq_inst[iq_wr[AW-1:0]] <= push_inst;
            iq_exc[iq_wr[AW-1:0]]  <= adef_push;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            halt        <= 1'b0;
            outstanding <= '0;
            cancel_cnt  <= '0;
            pend_wr     <= '0;
            pend_rd     <= '0;
            iq_wr       <= '0;
            iq_rd       <= '0;
        end else begin
            if (issue) begin
                pend_wr  <= pend_next(pend_wr);
                fetch_pc <= fetch_pc + 32'd4;
            end
            // Cancelled responses still retire their pending-PC slot, so the FIFO survives redirects.
            if (inst_sram_data_ok) pend_rd <= pend_next(pend_rd);
            outstanding <= outstanding + CW'(issue) - CW'(inst_sram_data_ok);
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc;
                halt       <= 1'b0;
                cancel_cnt <= cancel_cnt + outstanding
                            - CW'(inst_sram_data_ok && (cancel_cnt == '0));
                iq_wr      <= '0;
                iq_rd      <= '0;
            end else begin
                if (resp_drop) cancel_cnt <= cancel_cnt - CW'(1);
                if (iq_push)   iq_wr <= iq_wr + (AW+1)'(1);
                if (iq_pop)    iq_rd <= iq_rd + (AW+1)'(1);
                if (adef_push) halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !redirect_valid) assert (!(iq_push && iq_full && !iq_pop));
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_fetch_cnt  <= '0;
            perf_cancel_cnt <= '0;
        end else begin
            if (resp_keep) perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
            if (resp_drop) perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
        end
    end
`endif

endmodule
